fpalu_issue_ctrl: RTL and testbench

//  Initiator-side front end for the 32-bit pipelined FP add/multiply ALU (topdut).
//  - Accepts operations over a valid/ready request port and drives topdut a/b/s.
//  - topdut has no handshake and a fixed latency, so this block tracks every op in flight.
//  - Captures r/exception when each op's result emerges and returns it in issue order,

---
 rtl/fpalu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_fpalu_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_issue_ctrl.sv
// Issue/return front end for the fixed-latency pipelined FP add/multiply ALU.
// Optional synchronous flush port is enabled by defining FPALU_ISSUE_FLUSH_EN.
module fpalu_issue_ctrl #(
    parameter int unsigned LATENCY    = 29,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FPALU_ISSUE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_s,
    input  logic [31:0]      alu_r,
    input  logic             alu_exception,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_exception,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0]      data;
        logic             exc;
        logic [TAG_W-1:0] tag;
    } rsp_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [LATENCY-1:0] sh_v;
    logic [TAG_W-1:0] sh_tag [LATENCY];
    rsp_entry_t       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
    logic [CW-1:0]    credit, credit_d;
    logic             flush_c, fire_c, pop_c, wr_c;
    rsp_entry_t       head;

`ifdef FPALU_ISSUE_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Operands go straight to the ALU so it samples them on the accept edge.
    assign alu_a = req_a;
    assign alu_b = req_b;
    assign alu_s = req_op;

    assign req_ready = (state != STALL) && !flush_c;
    assign busy      = (state != IDLE);
    assign fire_c    = req_valid && req_ready;
    assign pop_c     = rsp_valid && rsp_ready && !flush_c;
    assign wr_c      = sh_v[LATENCY-1] && !flush_c;

    assign head          = fifo_mem[rd_ptr[AW-1:0]];
    assign rsp_data      = head.data;
    assign rsp_exception = head.exc;
    assign rsp_tag       = head.tag;

    // Next pointers, credit and derived occupancy state.
    always_comb begin
        state_d  = state;
        credit_d = credit;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        if (wr_c) wr_ptr_d = wr_ptr + PW'(1);
        if (pop_c) rd_ptr_d = rd_ptr + PW'(1);
        case ({fire_c, pop_c})
            2'b10:   credit_d = credit - CW'(1);
            2'b01:   credit_d = credit + CW'(1);
            default: credit_d = credit;
        endcase
        if (flush_c) begin
            credit_d = CW'(FIFO_DEPTH);
            rd_ptr_d = wr_ptr;
        end
        if (credit_d == CW'(FIFO_DEPTH))
            state_d = IDLE;
        else if (credit_d == CW'(0))
            state_d = STALL;
        else
            state_d = ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            credit    <= CW'(FIFO_DEPTH);
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_d;
            credit    <= credit_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            rsp_valid <= (wr_ptr_d != rd_ptr_d);
        end
    end

    // In-flight tracking: one slot per ALU pipeline stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_v <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) sh_tag[i] <= '0;
        end else begin
            sh_v[0]   <= fire_c && !flush_c;
            sh_tag[0] <= req_tag;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                sh_v[i]   <= sh_v[i-1] && !flush_c;
                sh_tag[i] <= sh_tag[i-1];
            end
        end
    end

    // Result capture; credit guarantees a free slot whenever wr_c is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (wr_c) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{data: alu_r, exc: alu_exception,
                                          tag: sh_tag[LATENCY-1]};
        end
    end

endmodule

// File: tb/tb_fpalu_issue_ctrl.sv
// Scoreboard bench for fpalu_issue_ctrl with a behavioural fixed-latency FP ALU model.
module tb_fpalu_issue_ctrl;
    localparam int unsigned LAT   = 29;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          req_valid, req_ready, req_op;
    logic [31:0]   req_a, req_b;
    logic [TW-1:0] req_tag;
    logic [31:0]   alu_a, alu_b, alu_r;
    logic          alu_s, alu_exception;
    logic          rsp_valid, rsp_ready, rsp_exception, busy;
    logic [31:0]   rsp_data;
    logic [TW-1:0] rsp_tag;

    always #5 clk = ~clk;

    fpalu_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
`ifdef FPALU_ISSUE_FLUSH_EN
        .flush(flush),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_tag(req_tag), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_r(alu_r), .alu_exception(alu_exception), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exception(rsp_exception),
        .rsp_tag(rsp_tag), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0]   d;
        logic          e;
        logic [TW-1:0] t;
        int            acc;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic real sp2r(input logic [31:0] a);
        logic [63:0] d;
        if (a[30:23] == 8'd0) return 0.0;
        d = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Reference FP op: {exception, result}; overflow saturates to infinity with exception.
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        real x, y, z;
        logic [63:0] d;
        int e;
        x = sp2r(a);
        y = sp2r(b);
        z = s ? x * y : x + y;
        if (z == 0.0) return 33'd0;
        d = $realtobits(z);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, d[63], 31'd0};
        return {1'b0, d[63], e[7:0], d[51:29]};
    endfunction

    logic [32:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_a, alu_b, alu_s);
        for (int i = LAT - 1; i > 0; i--) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_r         = alu_pipe[LAT-1][31:0];
    assign alu_exception = alu_pipe[LAT-1][32];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: occupancy model checks plus in-order response scoreboard.
    always @(negedge clk) begin
        logic fl;
        logic [32:0] r;
        exp_t h;
        exp_t n;
        if (!reset) begin
            fl = flush;
            check("req_ready", 64'(req_ready), 64'((sbq.size() < DEPTH) && !fl));
            check("busy", 64'(busy), 64'(sbq.size() != 0));
            check("rsp_valid", 64'(rsp_valid),
                  64'((sbq.size() != 0) && (sbq[0].acc + LAT <= cyc)));
            if (rsp_valid && rsp_ready && !fl) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    h = sbq.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(h.d));
                    check("rsp_exception", 64'(rsp_exception), 64'(h.e));
                    check("rsp_tag", 64'(rsp_tag), 64'(h.t));
                end
            end
            if (req_valid && req_ready) begin
                r = alu_f(req_a, req_b, req_op);
                n.d = r[31:0];
                n.e = r[32];
                n.t = req_tag;
                n.acc = cyc + 1;
                sbq.push_back(n);
            end
            if (fl) sbq.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
    endfunction

    task automatic rnd_req();
        req_a   = rnd_fp();
        req_b   = rnd_fp();
        req_op  = 1'($urandom);
        req_tag = TW'($urandom);
        if ($urandom_range(19, 0) == 0) begin
            req_a  = 32'h7F000000;
            req_b  = 32'h7F000000;
            req_op = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((sbq.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        check("drain_done", 64'(n < 200), 64'(1));
    endtask

    task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [TW-1:0] tag,
                          input logic [31:0] exp_d, input logic exp_e);
        int n = 1;
        rsp_ready = 1'b1;
        req_a = a; req_b = b; req_op = op; req_tag = tag;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'(LAT + 1));
        check({nm, "_data"}, 64'(rsp_data), 64'(exp_d));
        check({nm, "_exc"}, 64'(rsp_exception), 64'(exp_e));
        check({nm, "_tag"}, 64'(rsp_tag), 64'(tag));
        tick();
    endtask

    task automatic backpressure();
        int acc = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rnd_req();
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        check("bp_accepts", 64'(acc), 64'(DEPTH));
        check("bp_ready_low", 64'(req_ready), 64'(0));
        repeat (LAT + 2) tick();
        check("bp_full_ready", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        tick();
        check("bp_ready_first_pop", 64'(req_ready), 64'(1));
        drain();
    endtask

    task automatic load_midflight();
        int acc = 0;
        int n = 0;
        rsp_ready = 1'b0;
        while (acc < 2 && n < 20) begin
            rnd_req();
            req_valid = 1'b1;
            if (req_ready) acc++;
            tick();
            n++;
        end
        req_valid = 1'b0;
        repeat (LAT + 2) tick();
        while (acc < DEPTH && n < 40) begin
            rnd_req();
            req_valid = 1'b1;
            if (req_ready) acc++;
            tick();
            n++;
        end
        req_valid = 1'b0;
        repeat (5) tick();
        check("midflight_buffered", 64'(rsp_valid), 64'(1));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = 1'b0; req_tag = '0;
        #2;
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
        tick(); tick();
        reset = 1'b0;
        tick();

        single("add", 32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000, 1'b0);
        single("mul", 32'h40000000, 32'h40400000, 1'b1, 4'd5, 32'h40C00000, 1'b0);
        single("ovf", 32'h7F000000, 32'h7F000000, 1'b1, 4'd9, 32'h7F800000, 1'b1);

        backpressure();

        // Streaming: 40 mixed ops with the consumer always ready.
        rsp_ready = 1'b1;
        for (int k = 0, n = 0; k < 40 && n < 2000; n++) begin
            rnd_req();
            req_valid = 1'b1;
            if (req_ready) k++;
            tick();
        end
        drain();
        check("stream_idle", 64'(busy), 64'(0));

        // Random traffic with random backpressure.
        for (int k = 0; k < 600; k++) begin
            rnd_req();
            req_valid = ($urandom_range(3, 0) != 0);
            rsp_ready = ($urandom_range(2, 0) != 0);
            tick();
        end
        drain();

        // Reset with ops both buffered and in flight.
        load_midflight();
        reset = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
        sbq.delete();
        rsp_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (LAT + 10) tick();
        backpressure();

`ifdef FPALU_ISSUE_FLUSH_EN
        load_midflight();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_rsp_valid", 64'(rsp_valid), 64'(0));
        check("flush_busy", 64'(busy), 64'(0));
        rsp_ready = 1'b1;
        repeat (LAT + 10) tick();
        backpressure();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
